dnn_accel_hex_bank: RTL and testbench
=====================================

Name: dnn_accel_hex_bank

Overview:
- Parametrised successor to the single-digit seven-segment PIO.
- Drives NUM_DIGITS seven-segment displays from one Avalon-MM slave.
- Per digit: hex-nibble decode or raw segments, blanking, and hardware blink.
- Sits on the system interconnect beside the DNN accelerator, for status/result display.

Parameters:
NUM_DIGITS, 6, number of digits driven; legal range 1..8
ADDR_W, 4, word address width; must cover 4+NUM_DIGITS registers
BLINK_DIV, 25000000, clk cycles per blink half-period; minimum 2
ACTIVE_LOW, 1, 1 = segment lit by driving 0 (DE-series boards); 0 = lit by 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
address  input  ADDR_W  word address
chipselect  input  1  slave select
write_n  input  1  active-low write strobe; write = chipselect && !write_n
writedata  input  32  write data
readdata  output  32  read data; combinational from address, zero-latency
hex_out  output  7*NUM_DIGITS  registered segments; digit i at [7i+6:7i], bit0 = seg a ... bit6 = seg g

Behaviour:
- Register map (word addresses); unused bits read 0:
  - 0 VALUE: nibble i = [4i+3:4i], digit i hex value, 4*NUM_DIGITS bits.
  - 1 MODE: bit i, 0 = decode VALUE nibble, 1 = use RAW[i].
  - 2 BLANK: bit i, 1 = digit i dark.
  - 3 BLINK: bit i, 1 = digit i blinks.
  - 4+i RAW[i]: 7 bits, logical polarity (1 = lit).
- Addresses >= 4+NUM_DIGITS: writes ignored, reads return 0. Reads have no side effects.
- Reset (async assert, sync release is the system's job):
  - VALUE=0, MODE=0, BLANK=all ones, BLINK=0, RAW=0.
  - Counter=0, phase=0.
  - hex_out = all segments off (all ones if ACTIVE_LOW=1, all zeros otherwise).
- Decode (gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Per-digit priority, evaluated each cycle: BLANK=1 -> off; else BLINK=1 && phase=1 -> off; else MODE=1 -> RAW[i]; else decode(nibble i).
  - Final value XORed with all ones when ACTIVE_LOW=1, then registered into hex_out.
- Latency: write captured at edge N; hex_out reflects it after edge N+1. Phase change is reflected one edge after the toggle.
- Blink counter:
  - Free-runs 0..BLINK_DIV-1. At BLINK_DIV-1 it wraps to 0 and phase toggles.
  - phase=0 is the visible half.
  - Any write to BLINK clears counter and phase to 0, so blink restarts visible; this takes priority over a same-cycle terminal count.
- readdata: write and read in the same cycle at the same address return the pre-write value.
- Reset mid-blink or mid-write: all state returns to reset values immediately; a write coincident with reset is lost.

Optional Feature:
- Macro: HEX_BANK_BLINK_EN
- Defined: BLINK register, counter and phase exist as described.
- Undefined:
  - No counter or phase logic is synthesised; phase is treated as constant 0.
  - Address 3 reads 0 and writes are ignored.
  - All other behaviour is identical.

Test Plan:
- Reset with NUM_DIGITS=6, ACTIVE_LOW=1 -> hex_out = 42'h3FF_FFFF_FFFF; readdata at addr 2 = 0x3F, addr 0 = 0.
- Write BLANK=0, then VALUE=0x00123456 -> two edges after the VALUE write: digit0 = 7'h02 (~7D), digit5 = 7'h79 (~06); addr 0 reads 0x00123456.
- Write MODE=0x01, RAW[0]=0x49 -> digit0 = 7'h36; other digits unchanged; write to addr 15 ignored and reads 0.
- BLINK_DIV=4, write BLINK=0x02 -> digit1 visible 4 cycles, off 4 cycles, repeating. Rewrite BLINK mid-off-phase -> visible on the next output edge and counter restarts.
- Assert reset during the blink off-phase with digits showing -> hex_out all ones immediately (async); after release the display stays dark until BLANK is written.
- Compile without HEX_BANK_BLINK_EN, write BLINK=0x3F -> addr 3 reads 0; no digit ever blinks over 100 cycles.

Source files
------------

// File: rtl/dnn_accel_hex_bank.sv
`default_nettype none
// ============================================================================
// Module   : dnn_accel_hex_bank
// Purpose  : Avalon-MM bank of NUM_DIGITS seven-segment displays. Each digit
//            can show a decoded hex nibble or raw segments, and can be blanked
//            or blinked by hardware.
// Options  : define HEX_BANK_BLINK_EN to build the BLINK register and the
//            blink counter/phase. Without it, address 3 is a hole and no
//            digit ever blinks.
// Revision : 1.0 - initial release
// ============================================================================
module dnn_accel_hex_bank #(
  parameter int NUM_DIGITS = 6,
  parameter int ADDR_W     = 4,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int NW = 4 * NUM_DIGITS;
  localparam int HW = 7 * NUM_DIGITS;
  localparam logic [HW-1:0] HEX_OFF = (ACTIVE_LOW != 0) ? {HW{1'b1}} : {HW{1'b0}};

  // Hex nibble to gfedcba segments, logical polarity (1 = lit)
  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  default: decode = 7'h71;
    endcase
  endfunction

  logic                  w_wr;
  logic                  w_phase;
  logic [NUM_DIGITS-1:0] w_blink;
  logic                  unused_wdata;

  logic [NW-1:0]         value_q, value_d;
  logic [NUM_DIGITS-1:0] mode_q, mode_d;
  logic [NUM_DIGITS-1:0] blank_q, blank_d;
  logic [6:0]            raw_q [NUM_DIGITS];
  logic [6:0]            raw_d [NUM_DIGITS];
  logic [HW-1:0]         hex_q, hex_d;

  assign w_wr         = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // Next-state of the control registers from bus writes
  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    blank_d = blank_q;
    for (int i = 0; i < NUM_DIGITS; i++) raw_d[i] = raw_q[i];
    if (w_wr) begin
      if (address == ADDR_W'(0)) value_d = writedata[NW-1:0];
      if (address == ADDR_W'(1)) mode_d  = writedata[NUM_DIGITS-1:0];
      if (address == ADDR_W'(2)) blank_d = writedata[NUM_DIGITS-1:0];
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (address == ADDR_W'(4 + i)) raw_d[i] = writedata[6:0];
      end
    end
  end

  // Control registers; BLANK resets to all ones so the display starts dark
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      mode_q  <= '0;
      blank_q <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= '0;
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      blank_q <= blank_d;
      for (int i = 0; i < NUM_DIGITS; i++) raw_q[i] <= raw_d[i];
    end
  end

`ifdef HEX_BANK_BLINK_EN
  localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic                  w_wr_blink;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;

  assign w_wr_blink = w_wr && (address == ADDR_W'(3));

  // Blink divider: toggles phase at terminal count; a BLINK write restarts
  // it in the visible half and wins over a coincident terminal count
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
    if (w_wr_blink) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
    blink_d = w_wr_blink ? writedata[NUM_DIGITS-1:0] : blink_q;
  end

  // Blink state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
      blink_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
    end
  end

  assign w_phase = phase_q;
  assign w_blink = blink_q;
`else
  assign w_phase = 1'b0;
  assign w_blink = '0;
`endif

  // Per-digit segment selection: blank beats blink, blink beats source
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [6:0] w_seg;
    // Choose segments for this digit and apply board polarity
    always_comb begin
      w_seg = mode_q[gi] ? raw_q[gi] : decode(value_q[4*gi +: 4]);
      if (w_blink[gi] && w_phase) w_seg = 7'h00;
      if (blank_q[gi])            w_seg = 7'h00;
      hex_d[7*gi +: 7] = (ACTIVE_LOW != 0) ? ~w_seg : w_seg;
    end
  end

  // Output register; reset forces every segment off
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hex_q <= HEX_OFF;
    else       hex_q <= hex_d;
  end

  assign hex_out = hex_q;

  // Zero-latency read mux; holes and unused bits read as zero
  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(0)) readdata[NW-1:0]         = value_q;
    if (address == ADDR_W'(1)) readdata[NUM_DIGITS-1:0] = mode_q;
    if (address == ADDR_W'(2)) readdata[NUM_DIGITS-1:0] = blank_q;
`ifdef HEX_BANK_BLINK_EN
    if (address == ADDR_W'(3)) readdata[NUM_DIGITS-1:0] = blink_q;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (address == ADDR_W'(4 + i)) readdata[6:0] = raw_q[i];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dnn_accel_hex_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dnn_accel_hex_bank
// Purpose  : Self-checking bench for dnn_accel_hex_bank (6 digits, active-low,
//            BLINK_DIV=4). A register-level model predicts hex_out each cycle;
//            directed steps pin the model with literal values.
// Options  : honours HEX_BANK_BLINK_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dnn_accel_hex_bank;

  localparam int ND  = 6;
  localparam int DIV = 4;
`ifdef HEX_BANK_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif
  localparam logic [6:0] SEG [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          reset;
  logic [3:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [41:0]   hex_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  dnn_accel_hex_bank #(.NUM_DIGITS(ND), .ADDR_W(4), .BLINK_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .hex_out(hex_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [23:0] m_value;
  logic [5:0]  m_mode, m_blank, m_blink;
  logic [6:0]  m_raw [ND];
  int          m_k;        // edges since blink restart
  logic [41:0] exp_hex;

  function automatic logic [41:0] model_hex();
    logic [41:0] h;
    bit off_phase;
    off_phase = BLINK_ON && (((m_k / DIV) % 2) == 1);
    for (int i = 0; i < ND; i++) begin
      logic [6:0] s;
      if (m_blank[i])                    s = 7'h00;
      else if (m_blink[i] && off_phase)  s = 7'h00;
      else if (m_mode[i])                s = m_raw[i];
      else                               s = SEG[m_value[4*i +: 4]];
      h[7*i +: 7] = ~s;
    end
    return h;
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (a == 0) return {8'h0, m_value};
    if (a == 1) return {26'h0, m_mode};
    if (a == 2) return {26'h0, m_blank};
    if (a == 3) return BLINK_ON ? {26'h0, m_blink} : 32'h0;
    if (a >= 4 && a < 4 + ND) return {25'h0, m_raw[a-4]};
    return 32'h0;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_value <= '0; m_mode <= '0; m_blank <= '1; m_blink <= '0; m_k <= 0;
      for (int i = 0; i < ND; i++) m_raw[i] <= '0;
      exp_hex <= '1;
    end else begin
      exp_hex <= model_hex();
      m_k     <= m_k + 1;
      if (chipselect && !write_n) begin
        case (int'(address))
          0: m_value <= writedata[23:0];
          1: m_mode  <= writedata[5:0];
          2: m_blank <= writedata[5:0];
          3: if (BLINK_ON) begin m_blink <= writedata[5:0]; m_k <= 0; end
          default: if (address >= 4 && address < 4 + ND) m_raw[address-4] <= writedata[6:0];
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) if (chk_en) chk("hex_out_model", {22'h0, hex_out}, {22'h0, exp_hex});

  // ---------------- stimulus helpers ----------------
  task automatic wr(input int a, input logic [31:0] d);
    @(posedge clk); #2;
    address = 4'(a); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input int a, input logic [31:0] e, input string nm);
    @(negedge clk); #1;
    address = 4'(a); chipselect = 1'b1; write_n = 1'b1;
    #1 chk(nm, {32'h0, readdata}, {32'h0, e});
    chk({nm, "_model"}, {32'h0, readdata}, {32'h0, m_read(a)});
    chipselect = 1'b0;
  endtask

  task automatic edge_chk(input string nm, input logic [41:0] e);
    @(posedge clk); #1;
    chk(nm, {22'h0, hex_out}, {22'h0, e});
  endtask

  // Watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    chk("reset_hex", {22'h0, hex_out}, {22'h0, 42'h3FF_FFFF_FFFF});
    @(posedge clk); #3 reset = 1'b0;
    rd_chk(2, 32'h3F, "reset_blank");
    rd_chk(0, 32'h0,  "reset_value");

    // Decode path
    wr(2, 32'h0);
    wr(0, 32'h0012_3456);
    edge_chk("value_dig", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    chk("dig0", {57'h0, hex_out[6:0]},   {57'h0, 7'h02});
    chk("dig5", {57'h0, hex_out[41:35]}, {57'h0, 7'h79});
    rd_chk(0, 32'h0012_3456, "read_value");

    // Raw segments and ignored address
    wr(1, 32'h01);
    wr(4, 32'h49);
    edge_chk("raw_dig0", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h36});
    wr(15, 32'hFFFF_FFFF);
    rd_chk(15, 32'h0, "read_hole");
    rd_chk(4, 32'h49, "read_raw0");
    wr(1, 32'h00);

`ifdef HEX_BANK_BLINK_EN
    // Digit 1 shows 5 (~6D = 12) for DIV edges, then off for DIV edges
    wr(3, 32'h02);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      chk("blink_dig1", {57'h0, hex_out[13:7]}, {57'h0, (j <= DIV) ? 7'h12 : 7'h7F});
    end
    wr(3, 32'h02);
    for (int j = 1; j <= 9; j++) begin
      @(posedge clk); #1;
      chk("blink_restart", {57'h0, hex_out[13:7]}, {57'h0, (j <= DIV || j == 9) ? 7'h12 : 7'h7F});
    end
    rd_chk(3, 32'h02, "read_blink");
    wr(3, 32'h02);
    repeat (5) @(posedge clk);
    #1 chk("pre_reset_off", {57'h0, hex_out[13:7]}, {57'h0, 7'h7F});
`else
    wr(3, 32'h3F);
    rd_chk(3, 32'h0, "read_blink_absent");
    for (int j = 0; j < 100; j++) begin
      @(posedge clk); #1;
      chk("no_blink", {57'h0, hex_out[13:7]}, {57'h0, 7'h12});
    end
`endif

    // Asynchronous reset mid-display
    @(posedge clk); #3 reset = 1'b1;
    #1 chk("async_reset", {22'h0, hex_out}, {22'h0, 42'h3FF_FFFF_FFFF});
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    for (int j = 0; j < 10; j++) edge_chk("dark_after_reset", 42'h3FF_FFFF_FFFF);
    wr(2, 32'h0);
    edge_chk("zeros_shown", {6{7'h40}});

    // Randomized traffic; reads checked against the model (pre-write value)
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #2;
      address    = 4'($urandom_range(0, 15));
      writedata  = $urandom;
      chipselect = ($urandom_range(0, 3) != 0);
      write_n    = ($urandom_range(0, 2) != 0);
      if (address == 4'd3 && $urandom_range(0, 3) != 0) write_n = 1'b1;
      if (address == 4'd2) writedata[5:0] = 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      #1 chk("rand_read", {32'h0, readdata}, {32'h0, m_read(int'(address))});
    end
    @(posedge clk); #2 chipselect = 1'b0; write_n = 1'b1;
    repeat (3) @(posedge clk);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
